// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmit sequencer. Takes the THR byte and the line-control settings
//   from the register block, generates baud timing from the {DLH,DLL}
//   divisor and serialises start / data (LSB first) / optional parity / stop
//   bits onto uart_txd. All outputs are registered.
//
// Ports
//   sys_clk             system clock, rising edge
//   rst_b               asynchronous active-low reset
//   reg_ctrl_thr_vld    THR holds an unsent byte
//   reg_ctrl_thr_data   THR byte
//   reg_ctrl_dllh_data  baud divisor {DLH,DLL}; 0 inhibits transmission
//   reg_ctrl_lcr_dls    data length 00=5 .. 11=8 bits
//   reg_ctrl_lcr_stop   0=1 stop bit, 1=2 stop bits (1.5 when dls=00)
//   reg_ctrl_lcr_pen    parity enable
//   reg_ctrl_lcr_eps    1=even parity, 0=odd parity
//   ctrl_reg_thr_read   one-cycle pulse: THR byte taken into the shifter
//   ctrl_reg_thsr_empty shifter idle, no frame in progress
//   ctrl_reg_busy       frame in progress
//   uart_txd            serial TX line, idle high
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic             sys_clk,
    input  logic             rst_b,
    input  logic             reg_ctrl_thr_vld,
    input  logic [7:0]       reg_ctrl_thr_data,
    input  logic [DIV_W-1:0] reg_ctrl_dllh_data,
    input  logic [1:0]       reg_ctrl_lcr_dls,
    input  logic             reg_ctrl_lcr_stop,
    input  logic             reg_ctrl_lcr_pen,
    input  logic             reg_ctrl_lcr_eps,
    output logic             ctrl_reg_thr_read,
    output logic             ctrl_reg_thsr_empty,
    output logic             ctrl_reg_busy,
    output logic             uart_txd
);

    // Tick counter must reach 2*OVERSAMPLE-1 for a two-bit stop period.
    localparam int unsigned TW = $clog2(2 * OVERSAMPLE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_baud;
    logic [TW-1:0]    r_tick;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_par;

    // Frame-local copies of the line settings, frozen at the load edge.
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_dls;
    logic             r_stop;
    logic             r_pen;
    logic             r_eps;

    logic             r_txd;
    logic             r_thr_read;
    logic             r_busy;
    logic             r_empty;

    logic             w_tick;
    logic             w_bit_end;
    logic [TW-1:0]    w_last_tick;
    logic             w_load;

    // Number of ticks in the current bit period; only STOP is longer.
    always_comb begin
        w_last_tick = TW'(OVERSAMPLE - 1);
        if (r_state == ST_STOP && r_stop) begin
            if (r_dls == 2'b00) begin
                w_last_tick = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
            end else begin
                w_last_tick = TW'(2 * OVERSAMPLE - 1);
            end
        end
    end

    always_comb begin
        w_tick    = (r_state != ST_IDLE) && (r_baud == r_div - DIV_W'(1));
        w_bit_end = w_tick && (r_tick == w_last_tick);
        w_load    = ((r_state == ST_IDLE) || (r_state == ST_STOP && w_bit_end)) &&
                    reg_ctrl_thr_vld && (reg_ctrl_dllh_data != '0);
    end

    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_tick     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_div      <= '0;
            r_dls      <= '0;
            r_stop     <= 1'b0;
            r_pen      <= 1'b0;
            r_eps      <= 1'b0;
            r_txd      <= 1'b1;
            r_thr_read <= 1'b0;
            r_busy     <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            r_thr_read <= w_load;

            // Baud / tick timing runs for the whole frame.
            if (r_state != ST_IDLE) begin
                if (w_tick) begin
                    r_baud <= '0;
                    r_tick <= w_bit_end ? '0 : r_tick + TW'(1);
                end else begin
                    r_baud <= r_baud + DIV_W'(1);
                end
            end

            if (w_load) begin
                // Covers both IDLE and end-of-STOP, so back-to-back frames
                // start with no idle gap.
                r_shift <= reg_ctrl_thr_data;
                r_div   <= reg_ctrl_dllh_data;
                r_dls   <= reg_ctrl_lcr_dls;
                r_stop  <= reg_ctrl_lcr_stop;
                r_pen   <= reg_ctrl_lcr_pen;
                r_eps   <= reg_ctrl_lcr_eps;
                r_baud  <= '0;
                r_tick  <= '0;
                r_bit   <= '0;
                r_par   <= 1'b0;
                r_txd   <= 1'b0;
                r_busy  <= 1'b1;
                r_empty <= 1'b0;
                r_state <= ST_START;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_empty <= 1'b1;
                    end
                    ST_START: begin
                        if (w_bit_end) begin
                            // Parity accumulates each bit as it goes out.
                            r_txd   <= r_shift[0];
                            r_par   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (w_bit_end) begin
                            if (r_bit == 3'd4 + {1'b0, r_dls}) begin
                                if (r_pen) begin
                                    r_txd   <= r_eps ? r_par : ~r_par;
                                    r_state <= ST_PARITY;
                                end else begin
                                    r_txd   <= 1'b1;
                                    r_state <= ST_STOP;
                                end
                            end else begin
                                r_txd   <= r_shift[0];
                                r_par   <= r_par ^ r_shift[0];
                                r_shift <= r_shift >> 1;
                                r_bit   <= r_bit + 3'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_bit_end) begin
                            r_txd   <= 1'b1;
                            r_state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (w_bit_end) begin
                            r_txd   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_empty <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_empty <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ctrl_reg_thr_read   = r_thr_read;
    assign ctrl_reg_thsr_empty = r_empty;
    assign ctrl_reg_busy       = r_busy;
    assign uart_txd            = r_txd;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Directed bench for uart_tx_ctrl. A frame-level model builds the expected
//   per-cycle TX waveform whenever a load is due; a compare process checks
//   every output on every falling edge. Literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst_b   = 1'b0;
    logic        thr_vld = 1'b0;
    logic [7:0]  thr_data = 8'h00;
    logic [15:0] div     = 16'd1;
    logic [1:0]  dls     = 2'b11;
    logic        stp     = 1'b0;
    logic        pen     = 1'b0;
    logic        eps     = 1'b0;

    logic        thr_read;
    logic        thsr_empty;
    logic        busy;
    logic        txd;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    bit chk_en   = 1'b0;

    uart_tx_ctrl #(
        .OVERSAMPLE(16),
        .DIV_W     (16)
    ) dut (
        .sys_clk            (sys_clk),
        .rst_b              (rst_b),
        .reg_ctrl_thr_vld   (thr_vld),
        .reg_ctrl_thr_data  (thr_data),
        .reg_ctrl_dllh_data (div),
        .reg_ctrl_lcr_dls   (dls),
        .reg_ctrl_lcr_stop  (stp),
        .reg_ctrl_lcr_pen   (pen),
        .reg_ctrl_lcr_eps   (eps),
        .ctrl_reg_thr_read  (thr_read),
        .ctrl_reg_thsr_empty(thsr_empty),
        .ctrl_reg_busy      (busy),
        .uart_txd           (txd)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit m_wave[$];
    int m_pos  = 0;
    bit m_busy = 1'b0;
    bit m_rd   = 1'b0;

    function automatic void build_frame();
        int bt;
        int nb;
        int st;
        bit par;
        m_wave.delete();
        bt  = 16 * int'(div);
        nb  = 5 + int'(dls);
        par = 1'b0;
        for (int i = 0; i < bt; i++) m_wave.push_back(1'b0);
        for (int b = 0; b < nb; b++) begin
            par = par ^ thr_data[b];
            for (int i = 0; i < bt; i++) m_wave.push_back(thr_data[b]);
        end
        if (pen) begin
            for (int i = 0; i < bt; i++) m_wave.push_back(eps ? par : !par);
        end
        st = !stp ? 16 : ((dls == 2'b00) ? 24 : 32);
        for (int i = 0; i < st * int'(div); i++) m_wave.push_back(1'b1);
    endfunction

    always @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            m_busy = 1'b0;
            m_rd   = 1'b0;
            m_pos  = 0;
        end else begin
            m_rd = 1'b0;
            if (m_busy) begin
                m_pos++;
                if (m_pos >= m_wave.size()) m_busy = 1'b0;
            end
            if (!m_busy && thr_vld && div != 16'd0) begin
                build_frame();
                m_busy = 1'b1;
                m_pos  = 0;
                m_rd   = 1'b1;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (rst_b && thr_read) pulses++;
        if (chk_en) begin
            check("txd",        {31'd0, txd},        {31'd0, (m_busy ? m_wave[m_pos] : 1'b1)});
            check("busy",       {31'd0, busy},       {31'd0, m_busy});
            check("thsr_empty", {31'd0, thsr_empty}, {31'd0, !m_busy});
            check("thr_read",   {31'd0, thr_read},   {31'd0, m_rd});
        end
    end

    // ---------------- stimulus helpers ----------------
    bit cap[$];

    // Raise thr_vld at a falling edge and wait (bounded) for the pulse.
    task automatic start_frame(output int waitn);
        @(negedge sys_clk);
        thr_vld = 1'b1;
        waitn   = 0;
        do begin
            @(negedge sys_clk);
            waitn++;
        end while (!thr_read && waitn < 50);
        thr_vld = 1'b0;
    endtask

    // Capture txd per cycle while busy; optionally write a second byte.
    task automatic collect(input int inject_at, input logic [7:0] second, output int len);
        cap.delete();
        len = 0;
        while (busy && len < 4000) begin
            cap.push_back(txd);
            len++;
            if (len == inject_at) begin
                thr_data = second;
                thr_vld  = 1'b1;
            end
            @(negedge sys_clk);
            if (thr_read) thr_vld = 1'b0;
        end
    endtask

    function automatic logic [31:0] mid_bits(input int nbits, input int bt);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < nbits; b++) begin
            if (b * bt + bt / 2 < cap.size()) v[b] = cap[b * bt + bt / 2];
        end
        return v;
    endfunction

    initial begin
        int w;
        int len;
        int p0;

        // reset and idle
        repeat (3) @(negedge sys_clk);
        rst_b  = 1'b1;
        chk_en = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("idle_txd",   {31'd0, txd},        32'd1);
        check("idle_empty", {31'd0, thsr_empty}, 32'd1);
        check("idle_busy",  {31'd0, busy},       32'd0);
        check("idle_pulses", pulses,             32'd0);

        // div=1, 8N1, 0x55
        div = 16'd1; dls = 2'b11; stp = 1'b0; pen = 1'b0; eps = 1'b0; thr_data = 8'h55;
        p0 = pulses;
        start_frame(w);
        check("55_pulse_latency", w, 32'd1);
        collect(0, 8'h00, len);
        check("55_bits", mid_bits(10, 16), 32'h2AA);
        check("55_busy_len", len, 32'd160);
        check("55_pulses", pulses - p0, 32'd1);
        repeat (3) @(negedge sys_clk);

        // div=2, 7E1 and 7O1, 0x41
        div = 16'd2; dls = 2'b10; pen = 1'b1; eps = 1'b1; thr_data = 8'h41;
        start_frame(w);
        collect(0, 8'h00, len);
        check("7E1_parity", {31'd0, (cap.size() > 272) ? cap[272] : 1'b1}, 32'd0);
        check("7E1_len", len, 32'd320);
        repeat (3) @(negedge sys_clk);
        eps = 1'b0;
        start_frame(w);
        collect(0, 8'h00, len);
        check("7O1_parity", {31'd0, (cap.size() > 272) ? cap[272] : 1'b0}, 32'd1);
        check("7O1_len", len, 32'd320);
        repeat (3) @(negedge sys_clk);

        // stop-length variants at div=1
        div = 16'd1; pen = 1'b0; stp = 1'b1; dls = 2'b00; thr_data = 8'h1F;
        start_frame(w);
        collect(0, 8'h00, len);
        check("5N1.5_len", len, 32'd120);
        repeat (3) @(negedge sys_clk);
        dls = 2'b11;
        start_frame(w);
        collect(0, 8'h00, len);
        check("8N2_len", len, 32'd176);
        check("8N2_last_data", {31'd0, (cap.size() > 143) ? cap[143] : 1'b1}, 32'd0);
        repeat (3) @(negedge sys_clk);

        // back-to-back: 0xA5 then 0x3C written mid-frame; lcr changed mid-frame too
        stp = 1'b0; thr_data = 8'hA5;
        p0 = pulses;
        start_frame(w);
        pen = 1'b1;
        collect(50, 8'h3C, len);
        check("b2b_len", len, 32'd336);
        check("b2b_pulses", pulses - p0, 32'd2);
        check("b2b_stop_end", {31'd0, (cap.size() > 159) ? cap[159] : 1'b0}, 32'd1);
        check("b2b_start2", {31'd0, (cap.size() > 160) ? cap[160] : 1'b1}, 32'd0);
        pen = 1'b0;
        repeat (3) @(negedge sys_clk);

        // div=0 holds THR, then div=1 loads, then reset mid-DATA
        thr_data = 8'h00; div = 16'd0; thr_vld = 1'b1;
        p0 = pulses;
        repeat (100) @(negedge sys_clk);
        check("div0_pulses", pulses - p0, 32'd0);
        check("div0_busy", {31'd0, busy}, 32'd0);
        div = 16'd1;
        start_frame(w);
        check("div1_pulse", pulses - p0, 32'd1);
        repeat (40) @(negedge sys_clk);
        check("pre_rst_txd", {31'd0, txd}, 32'd0);
        #2 rst_b = 1'b0;
        #1;
        check("rst_txd",   {31'd0, txd},        32'd1);
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_empty", {31'd0, thsr_empty}, 32'd1);
        check("rst_read",  {31'd0, thr_read},   32'd0);
        @(negedge sys_clk);
        rst_b = 1'b1;
        repeat (10) @(negedge sys_clk);
        check("post_rst_pulses", pulses - p0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
